// File: rtl/selen_wb_uart.sv
// selen_wb_uart: Wishbone classic slave UART (8N1) for the CPU console.
// A TX_DEPTH-entry FIFO feeds the transmit shifter; the receiver synchronises
// uart_rx_i, samples mid-bit and holds one byte. There is a programmable
// baud divisor and a registered level interrupt.
module selen_wb_uart #(
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_DEPTH);

  // Shared state encoding for both serial FSMs
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // Bus request capture
  logic        r_ack, r_err, r_we;
  logic [1:0]  r_reg, r_sel;
  logic [15:0] r_wdat;
  logic        w_req, w_bad;

  // Control / status
  logic [15:0] r_div;
  logic [1:0]  r_ctrl;
  logic        r_rx_valid, r_rx_ovr, r_frm_err, r_tx_ovf, r_irq;
  logic [7:0]  r_rx_data;
  logic [15:0] w_div_eff;

  // Register strobes, all qualified by the termination cycle
  logic w_wr, w_rd, w_push_req, w_rd_data, w_w1c, w_div_wr, w_ctrl_wr;

  // TX FIFO
  logic [7:0]       r_fifo [TX_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full, w_empty, w_push, w_pop, w_ovf_set;

  // TX FSM
  logic [1:0]  r_tx_state, w_tx_state_d;
  logic [15:0] r_tx_cnt, w_tx_cnt_d;
  logic [7:0]  r_tx_sh, w_tx_sh_d;
  logic [2:0]  r_tx_bit, w_tx_bit_d;
  logic        r_tx, w_tx_d, w_tx_tick, w_tx_idle;

  // RX FSM
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]  r_rx_state, w_rx_state_d;
  logic [15:0] r_rx_cnt, w_rx_cnt_d;
  logic [7:0]  r_rx_sh, w_rx_sh_d;
  logic [2:0]  r_rx_bit, w_rx_bit_d;
  logic        w_rx_tick, w_rx_good, w_rx_bad;

  logic [31:0] w_rdata;
  logic        w_unused;

  // Address decode lives in the crossbar; only these bits matter here
  assign w_unused = ^{wb_adr_i[31:12], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_bad = |wb_adr_i[11:4];

  // Bus front end: register the request, terminate one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_we   <= 1'b0;
      r_reg  <= REG_DATA;
      r_sel  <= 2'b00;
      r_wdat <= 16'h0;
    end else begin
      r_ack <= w_req & ~w_bad;
      r_err <= w_req & w_bad;
      if (w_req) begin
        r_we   <= wb_we_i;
        r_reg  <= wb_adr_i[3:2];
        r_sel  <= wb_sel_i[1:0];
        r_wdat <= wb_dat_i[15:0];
      end
    end
  end

  assign w_wr       = r_ack & r_we;
  assign w_rd       = r_ack & ~r_we;
  assign w_push_req = w_wr & (r_reg == REG_DATA) & r_sel[0];
  assign w_rd_data  = w_rd & (r_reg == REG_DATA);
  assign w_w1c      = w_wr & (r_reg == REG_STATUS) & r_sel[0];
  assign w_div_wr   = w_wr & (r_reg == REG_DIV) & (r_sel == 2'b11);
  assign w_ctrl_wr  = w_wr & (r_reg == REG_CTRL) & r_sel[0];

  assign w_div_eff = (r_div < 16'd2) ? 16'd2 : r_div;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= r_wdat[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_tx_tick = (r_tx_cnt == 16'h0);
  assign w_tx_idle = w_empty & (r_tx_state == ST_IDLE);

  // TX next state; the divisor is reloaded at every bit boundary
  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_cnt_d   = (r_tx_state == ST_IDLE || w_tx_tick) ? r_tx_cnt : r_tx_cnt - 16'd1;
    w_tx_sh_d    = r_tx_sh;
    w_tx_bit_d   = r_tx_bit;
    w_pop        = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_tx_sh_d    = r_fifo[r_rptr];
          w_tx_state_d = ST_START;
          w_tx_cnt_d   = w_div_eff - 16'd1;
        end
      end
      ST_START: begin
        if (w_tx_tick) begin
          w_tx_state_d = ST_DATA;
          w_tx_cnt_d   = w_div_eff - 16'd1;
          w_tx_bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_tx_tick) begin
          w_tx_cnt_d = w_div_eff - 16'd1;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_d = ST_STOP;
          end else begin
            w_tx_sh_d  = {1'b0, r_tx_sh[7:1]};
            w_tx_bit_d = r_tx_bit + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tx_tick) begin
          // Chain straight into the next frame when data is waiting
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_tx_sh_d    = r_fifo[r_rptr];
            w_tx_state_d = ST_START;
            w_tx_cnt_d   = w_div_eff - 16'd1;
          end else begin
            w_tx_state_d = ST_IDLE;
          end
        end
      end
      default: w_tx_state_d = ST_IDLE;
    endcase
  end

  // Line level follows the next state so uart_tx_o comes straight from a flop
  always_comb begin
    w_tx_d = 1'b1;
    if (w_tx_state_d == ST_START) w_tx_d = 1'b0;
    else if (w_tx_state_d == ST_DATA) w_tx_d = w_tx_sh_d[0];
  end

  // TX state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= 16'h0;
      r_tx_sh    <= 8'h0;
      r_tx_bit   <= 3'd0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_tx_sh    <= w_tx_sh_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx       <= w_tx_d;
    end
  end

  // Two-flop synchroniser plus edge history, all idling high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_rx_tick = (r_rx_cnt == 16'h0);

  // RX next state: half a bit to the start-bit centre, then whole bits
  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_cnt_d   = (r_rx_state == ST_IDLE || w_rx_tick) ? r_rx_cnt : r_rx_cnt - 16'd1;
    w_rx_sh_d    = r_rx_sh;
    w_rx_bit_d   = r_rx_bit;
    w_rx_good    = 1'b0;
    w_rx_bad     = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_d = ST_START;
          w_rx_cnt_d   = {1'b0, w_div_eff[15:1]} - 16'd1;
        end
      end
      ST_START: begin
        if (w_rx_tick) begin
          if (r_rx_s2) begin
            w_rx_state_d = ST_IDLE;
          end else begin
            w_rx_state_d = ST_DATA;
            w_rx_cnt_d   = w_div_eff - 16'd1;
            w_rx_bit_d   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_tick) begin
          w_rx_sh_d  = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_cnt_d = w_div_eff - 16'd1;
          if (r_rx_bit == 3'd7) w_rx_state_d = ST_STOP;
          else w_rx_bit_d = r_rx_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_rx_tick) begin
          w_rx_state_d = ST_IDLE;
          w_rx_good    = r_rx_s2;
          w_rx_bad     = ~r_rx_s2;
        end
      end
      default: w_rx_state_d = ST_IDLE;
    endcase
  end

  // RX state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= 16'h0;
      r_rx_sh    <= 8'h0;
      r_rx_bit   <= 3'd0;
    end else begin
      r_rx_state <= w_rx_state_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_rx_sh    <= w_rx_sh_d;
      r_rx_bit   <= w_rx_bit_d;
    end
  end

  // Status flags: hardware set events take priority over W1C
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h0;
      r_rx_ovr   <= 1'b0;
      r_frm_err  <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      // A DATA read coinciding with a new byte makes room for it
      if (w_rx_good && (!r_rx_valid || w_rd_data)) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_rx_sh;
      end else if (w_rd_data) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_good && r_rx_valid && !w_rd_data) r_rx_ovr <= 1'b1;
      else if (w_w1c && r_wdat[1])               r_rx_ovr <= 1'b0;

      if (w_rx_bad)                 r_frm_err <= 1'b1;
      else if (w_w1c && r_wdat[4])  r_frm_err <= 1'b0;

      if (w_ovf_set)                r_tx_ovf <= 1'b1;
      else if (w_w1c && r_wdat[5])  r_tx_ovf <= 1'b0;
    end
  end

  // Divisor, interrupt enables and the registered interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div  <= DIV_RESET;
      r_ctrl <= 2'b00;
      r_irq  <= 1'b0;
    end else begin
      if (w_div_wr)  r_div  <= r_wdat;
      if (w_ctrl_wr) r_ctrl <= r_wdat[1:0];
      r_irq <= (r_rx_valid & r_ctrl[0]) | (w_tx_idle & r_ctrl[1]);
    end
  end

  // Read mux, only driven during an ack
  always_comb begin
    w_rdata = 32'h0;
    if (w_rd) begin
      case (r_reg)
        REG_DATA:   w_rdata = {24'h0, r_rx_data};
        REG_STATUS: w_rdata = {26'h0, r_tx_ovf, r_frm_err, w_tx_idle, w_full, r_rx_ovr,
                               r_rx_valid};
        REG_DIV:    w_rdata = {16'h0, r_div};
        REG_CTRL:   w_rdata = {30'h0, r_ctrl};
        default:    w_rdata = 32'h0;
      endcase
    end
  end

  assign wb_dat_o  = w_rdata;
  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign uart_tx_o = r_tx;
  assign irq_o     = r_irq;

endmodule
